// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS-subset controller.
//   - opcode / funct constants for the supported instructions
//   - 4-bit FSM state enum
//   - datapath mux-select encodings (aluOp, pcSrc, aluSrcB, regDst, wbSel)
//   - one-hot instruction class produced by mc_decode
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EXE_R   = 4'd2,
    S_WB_R    = 4'd3,
    S_EXE_I   = 4'd4,
    S_WB_I    = 4'd5,
    S_MEM_ADR = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_WB_LD   = 4'd9,
    S_BR      = 4'd10
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  localparam logic [1:0] PC_INC  = 2'd0;  // ALU result (PC+4)
  localparam logic [1:0] PC_BR   = 2'd1;  // ALUOut (branch target from ID)
  localparam logic [1:0] PC_JMP  = 2'd2;  // {PC[31:28], IR[25:0], 2'b00}

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM4 = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_RA  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;

  typedef struct packed {
    logic rtype_add;
    logic rtype_sub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic illegal;
  } inst_cls_t;

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: controller <-> datapath bundle.
//   master (controller): reads op/funct/zero, drives all strobes and selects.
//   slave  (datapath):   the mirror image.
interface mc_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcW;
  logic       irW;
  logic       regW;
  logic       memW;
  logic [1:0] pcSrc;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       extOp;
  logic [1:0] regDst;
  logic [1:0] wbSel;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcW, irW, regW, memW, pcSrc, aluSrcA, aluSrcB, aluOp,
           extOp, regDst, wbSel, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  pcW, irW, regW, memW, pcSrc, aluSrcA, aluSrcB, aluOp,
           extOp, regDst, wbSel, illegal, state
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
//   op, funct : IR[31:26], IR[5:0]
//   cls       : one-hot class; anything unsupported sets cls.illegal
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output inst_cls_t  cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.rtype_add = 1'b1;
          FN_SUBU: cls.rtype_sub = 1'b1;
          default: cls.illegal   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle control FSM for the MIPS-subset CPU.
//   CLK   : system clock (rising edge)
//   Reset : synchronous, active-high; returns the FSM to IF
//   bus   : mc_control_if.master -- op/funct/zero in; pcW, irW, regW, memW,
//           pcSrc, aluSrcA, aluSrcB, aluOp, extOp, regDst, wbSel, illegal,
//           state out. All outputs are combinational from state/op/funct/zero.
module mc_control
  import mc_ctrl_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset,
  mc_control_if.master bus
);

  state_e    state_q, state_d;
  inst_cls_t cls;

  logic       pc_w, ir_w, reg_w, mem_w, ill;
  logic       src_a, ext_op;
  logic [1:0] pc_src, src_b, alu_op, reg_dst, wb_sel;

  mc_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (cls)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (cls.rtype_add || cls.rtype_sub) state_d = S_EXE_R;
        else if (cls.ori || cls.lui)        state_d = S_EXE_I;
        else if (cls.lw || cls.sw)          state_d = S_MEM_ADR;
        else if (cls.beq)                   state_d = S_BR;
        else                                state_d = S_IF;  // j, jal, illegal
      end
      S_EXE_R:   state_d = S_WB_R;
      S_EXE_I:   state_d = S_WB_I;
      S_MEM_ADR: state_d = cls.lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = S_WB_LD;
      default:   state_d = S_IF;  // WB_*, MEM_WR, BR and unused codes
    endcase
  end

  // Output logic
  always_comb begin
    pc_w = 1'b0; ir_w = 1'b0; reg_w = 1'b0; mem_w = 1'b0; ill = 1'b0;
    src_a = 1'b0; ext_op = 1'b0;
    pc_src = PC_INC; src_b = SRCB_REG; alu_op = ALU_ADD;
    reg_dst = DST_RT; wb_sel = WB_ALU;
    case (state_q)
      S_IF: begin
        ir_w = 1'b1; pc_w = 1'b1; src_b = SRCB_4;
      end
      S_ID: begin
        // ALUOut picks up the branch target here; BR consumes it.
        src_b = SRCB_IMM4; ext_op = 1'b1;
        if (cls.j) begin
          pc_w = 1'b1; pc_src = PC_JMP;
        end else if (cls.jal) begin
          // PC already holds PC+4 from IF, so it is the link value.
          pc_w = 1'b1; pc_src = PC_JMP;
          reg_w = 1'b1; reg_dst = DST_RA; wb_sel = WB_PC;
        end else if (cls.illegal) begin
          ill = 1'b1;
        end
      end
      S_EXE_R: begin
        src_a = 1'b1; src_b = SRCB_REG;
        alu_op = cls.rtype_sub ? ALU_SUB : ALU_ADD;
      end
      S_WB_R: begin
        reg_w = 1'b1; reg_dst = DST_RD; wb_sel = WB_ALU;
      end
      S_EXE_I: begin
        src_a = 1'b1; src_b = SRCB_IMM; ext_op = 1'b0;
        alu_op = cls.lui ? ALU_LUI : ALU_OR;
      end
      S_WB_I: begin
        reg_w = 1'b1; reg_dst = DST_RT; wb_sel = WB_ALU;
      end
      S_MEM_ADR: begin
        src_a = 1'b1; src_b = SRCB_IMM; ext_op = 1'b1; alu_op = ALU_ADD;
      end
      S_MEM_WR: mem_w = 1'b1;
      S_WB_LD: begin
        reg_w = 1'b1; reg_dst = DST_RT; wb_sel = WB_MEM;
      end
      S_BR: begin
        src_a = 1'b1; src_b = SRCB_REG; alu_op = ALU_SUB;
        pc_w = bus.zero; pc_src = PC_BR;
      end
      default: ;
    endcase

    // A cycle with Reset high abandons the instruction: no strobe may fire,
    // and selects read as idle so the datapath sees a clean zero vector.
    if (Reset) begin
      pc_w = 1'b0; ir_w = 1'b0; reg_w = 1'b0; mem_w = 1'b0; ill = 1'b0;
      src_a = 1'b0; ext_op = 1'b0;
      pc_src = PC_INC; src_b = SRCB_REG; alu_op = ALU_ADD;
      reg_dst = DST_RT; wb_sel = WB_ALU;
    end
  end

  assign bus.pcW     = pc_w;
  assign bus.irW     = ir_w;
  assign bus.regW    = reg_w;
  assign bus.memW    = mem_w;
  assign bus.illegal = ill;
  assign bus.pcSrc   = pc_src;
  assign bus.aluSrcA = src_a;
  assign bus.aluSrcB = src_b;
  assign bus.aluOp   = alu_op;
  assign bus.extOp   = ext_op;
  assign bus.regDst  = reg_dst;
  assign bus.wbSel   = wb_sel;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed vectors for mc_control. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_mc_control;

  logic CLK = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  mc_control_if bus ();

  mc_control dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Sample one cycle: state and the strobe vector {pcW,irW,regW,memW,illegal}.
  task automatic smp(input string tag, input logic [3:0] es, input logic [4:0] ew);
    @(negedge CLK);
    chk({tag, "/state"}, 32'(bus.state), 32'(es));
    chk({tag, "/strb"},
        32'({bus.pcW, bus.irW, bus.regW, bus.memW, bus.illegal}), 32'(ew));
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] es, input logic [4:0] ew);
    smp(tag, es, ew);
    adv();
  endtask

  task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
    bus.op = o;
    bus.funct = f;
  endtask

  initial begin
    Reset = 1'b1;
    bus.zero = 1'b0;
    set_ir(6'h00, 6'h21);

    // Two reset cycles: state IF, everything idle.
    adv();
    smp("rst0", 4'd0, 5'b00000);
    chk("rst0/srcB", 32'(bus.aluSrcB), 32'd0);
    chk("rst0/pcSrc", 32'(bus.pcSrc), 32'd0);
    adv();
    smp("rst1", 4'd0, 5'b00000);
    chk("rst1/sel", 32'({bus.aluSrcA, bus.aluOp, bus.regDst, bus.wbSel, bus.extOp}), 32'd0);
    adv();
    Reset = 1'b0;

    // addu
    smp("addu/if", 4'd0, 5'b11000);
    chk("addu/if/srcB", 32'(bus.aluSrcB), 32'd1);
    chk("addu/if/pcSrc", 32'(bus.pcSrc), 32'd0);
    adv();
    smp("addu/id", 4'd1, 5'b00000);
    chk("addu/id/srcB", 32'(bus.aluSrcB), 32'd3);
    chk("addu/id/ext", 32'(bus.extOp), 32'd1);
    adv();
    smp("addu/exe", 4'd2, 5'b00000);
    chk("addu/exe/op", 32'(bus.aluOp), 32'd0);
    chk("addu/exe/srcA", 32'(bus.aluSrcA), 32'd1);
    adv();
    smp("addu/wb", 4'd3, 5'b00100);
    chk("addu/wb/dst", 32'(bus.regDst), 32'd1);
    adv();

    // subu
    set_ir(6'h00, 6'h23);
    step("subu/if", 4'd0, 5'b11000);
    step("subu/id", 4'd1, 5'b00000);
    smp("subu/exe", 4'd2, 5'b00000);
    chk("subu/exe/op", 32'(bus.aluOp), 32'd1);
    adv();
    step("subu/wb", 4'd3, 5'b00100);

    // ori
    set_ir(6'h0D, 6'h00);
    step("ori/if", 4'd0, 5'b11000);
    step("ori/id", 4'd1, 5'b00000);
    smp("ori/exe", 4'd4, 5'b00000);
    chk("ori/exe/op", 32'(bus.aluOp), 32'd2);
    chk("ori/exe/srcB", 32'(bus.aluSrcB), 32'd2);
    chk("ori/exe/ext", 32'(bus.extOp), 32'd0);
    adv();
    smp("ori/wb", 4'd5, 5'b00100);
    chk("ori/wb/dst", 32'(bus.regDst), 32'd0);
    adv();

    // lui
    set_ir(6'h0F, 6'h00);
    step("lui/if", 4'd0, 5'b11000);
    step("lui/id", 4'd1, 5'b00000);
    smp("lui/exe", 4'd4, 5'b00000);
    chk("lui/exe/op", 32'(bus.aluOp), 32'd3);
    adv();
    step("lui/wb", 4'd5, 5'b00100);

    // lw
    set_ir(6'h23, 6'h00);
    step("lw/if", 4'd0, 5'b11000);
    step("lw/id", 4'd1, 5'b00000);
    smp("lw/adr", 4'd6, 5'b00000);
    chk("lw/adr/srcB", 32'(bus.aluSrcB), 32'd2);
    chk("lw/adr/ext", 32'(bus.extOp), 32'd1);
    adv();
    step("lw/rd", 4'd7, 5'b00000);
    smp("lw/wb", 4'd9, 5'b00100);
    chk("lw/wb/wbSel", 32'(bus.wbSel), 32'd1);
    adv();

    // sw
    set_ir(6'h2B, 6'h00);
    step("sw/if", 4'd0, 5'b11000);
    step("sw/id", 4'd1, 5'b00000);
    step("sw/adr", 4'd6, 5'b00000);
    step("sw/wr", 4'd8, 5'b00010);

    // beq taken
    set_ir(6'h04, 6'h00);
    bus.zero = 1'b1;
    step("beq1/if", 4'd0, 5'b11000);
    step("beq1/id", 4'd1, 5'b00000);
    smp("beq1/br", 4'd10, 5'b10000);
    chk("beq1/br/pcSrc", 32'(bus.pcSrc), 32'd1);
    chk("beq1/br/op", 32'(bus.aluOp), 32'd1);
    adv();

    // beq not taken
    bus.zero = 1'b0;
    step("beq0/if", 4'd0, 5'b11000);
    step("beq0/id", 4'd1, 5'b00000);
    step("beq0/br", 4'd10, 5'b00000);

    // j
    set_ir(6'h02, 6'h00);
    step("j/if", 4'd0, 5'b11000);
    smp("j/id", 4'd1, 5'b10000);
    chk("j/id/pcSrc", 32'(bus.pcSrc), 32'd2);
    adv();

    // jal
    set_ir(6'h03, 6'h00);
    step("jal/if", 4'd0, 5'b11000);
    smp("jal/id", 4'd1, 5'b10100);
    chk("jal/id/pcSrc", 32'(bus.pcSrc), 32'd2);
    chk("jal/id/dst", 32'(bus.regDst), 32'd2);
    chk("jal/id/wbSel", 32'(bus.wbSel), 32'd2);
    adv();

    // illegal opcode, then illegal funct
    set_ir(6'h3F, 6'h00);
    step("ill1/if", 4'd0, 5'b11000);
    step("ill1/id", 4'd1, 5'b00001);
    set_ir(6'h00, 6'h00);
    step("ill2/if", 4'd0, 5'b11000);
    step("ill2/id", 4'd1, 5'b00001);

    // Reset while in MEM_WR
    set_ir(6'h2B, 6'h00);
    step("swr/if", 4'd0, 5'b11000);
    step("swr/id", 4'd1, 5'b00000);
    step("swr/adr", 4'd6, 5'b00000);
    Reset = 1'b1;
    step("swr/wr", 4'd8, 5'b00000);
    Reset = 1'b0;
    step("swr/after", 4'd0, 5'b11000);
    step("swr/id2", 4'd1, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control FSM for the single-issue MIPS-subset CPU. It sequences the shared datapath (PC register, IR, register file, single ALU, unified memory) across IF/ID/EXE/MEM/WB cycles. It is the sole source of the PC write enable `pcW` and of every other datapath write strobe and mux select. It sits between the IR opcode/funct fields plus the ALU `zero` flag and the datapath control inputs.

## Interface
- No parameters; all encodings live in `mc_ctrl_pkg`.
- `CLK` in 1: system clock, all state changes on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU result == 0.
- `pcW` out 1: PC write enable.
- `irW` out 1: IR write enable.
- `regW` out 1: register file write enable.
- `memW` out 1: data memory write enable.
- `pcSrc` out 2: next PC source. 0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump target {PC[31:28], IR[25:0], 2'b00}.
- `aluSrcA` out 1: ALU A operand. 0 = PC, 1 = register A.
- `aluSrcB` out 2: ALU B operand. 0 = register B, 1 = constant 4, 2 = ext(imm16), 3 = ext(imm16)<<2.
- `aluOp` out 2: 0 ADD, 1 SUB, 2 OR, 3 LUI (B<<16).
- `extOp` out 1: immediate extension. 1 = sign-extend, 0 = zero-extend.
- `regDst` out 2: write register. 0 = rt, 1 = rd, 2 = $31.
- `wbSel` out 2: write-back data. 0 = ALUOut, 1 = memory data register, 2 = current PC.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `state` out 4: current state, for debug and the bench.

## Operation
- Supported instructions: addu, subu (op 000000, funct 100001 / 100011); ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011.
- States and encodings:
  - IF=0, ID=1, EXE_R=2, WB_R=3, EXE_I=4, WB_I=5, MEM_ADR=6, MEM_RD=7, MEM_WR=8, WB_LD=9, BR=10.
  - Codes 11–15 are unused and return to IF.
- Outputs are combinational from `state`, `op`, `funct` and `zero`. Every enable, and every mux select, defaults to 0 unless listed for a state.
- IF:
  - `irW`=1, `pcW`=1, `pcSrc`=0, `aluSrcA`=0, `aluSrcB`=1, `aluOp`=ADD.
  - Next state is ID.
- ID:
  - Precomputes the branch target: `aluSrcA`=0, `aluSrcB`=3, `extOp`=1, `aluOp`=ADD.
  - Next state by instruction: R-type → EXE_R; ori/lui → EXE_I; lw/sw → MEM_ADR; beq → BR.
  - j: `pcW`=1, `pcSrc`=2, next state IF.
  - jal: `pcW`=1, `pcSrc`=2, `regW`=1, `regDst`=2, `wbSel`=2, next state IF. $31 receives the already-incremented PC.
  - Anything else: `illegal`=1, no writes, next state IF.
- EXE_R:
  - `aluSrcA`=1, `aluSrcB`=0.
  - `aluOp`=ADD for addu, SUB for subu.
  - Next state WB_R.
- WB_R: `regW`=1, `regDst`=1, `wbSel`=0. Next state IF.
- EXE_I:
  - `aluSrcA`=1, `aluSrcB`=2, `extOp`=0.
  - `aluOp`=OR for ori, LUI for lui.
  - Next state WB_I.
- WB_I: `regW`=1, `regDst`=0, `wbSel`=0. Next state IF.
- MEM_ADR: `aluSrcA`=1, `aluSrcB`=2, `extOp`=1, `aluOp`=ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: next state WB_LD.
- MEM_WR: `memW`=1. Next state IF.
- WB_LD: `regW`=1, `regDst`=0, `wbSel`=1. Next state IF.
- BR:
  - `aluSrcA`=1, `aluSrcB`=0, `aluOp`=SUB.
  - `pcW`=`zero`, `pcSrc`=1.
  - Next state IF.

## Timing
- Cycles per instruction, IF to next IF: R-type 4, ori/lui 4, lw 5, sw 4, beq 3, j/jal 2, illegal 2.
- `Reset` high at a rising edge: `state` becomes IF.
- While `Reset` is high, all of `pcW`, `irW`, `regW`, `memW` and `illegal` are forced to 0, whatever the state.
- After reset:
  - `state`=0 and all selects are 0.
  - The first fetch occurs in the first cycle with `Reset` low.
- Reset mid-instruction (any state): the instruction is abandoned and no write strobe is issued in the `Reset` cycle. The PC register reloads 0x00003000 on its own reset.
- `op`/`funct` are read only in ID and later states; the IR is stable there because `irW` is asserted only in IF.
- `zero` is sampled combinationally in BR only.

## Structure
- `mc_ctrl_pkg` holds:
  - opcode and funct constants;
  - the state enum (4-bit);
  - `aluOp`, `pcSrc`, `aluSrcB`, `regDst` and `wbSel` encodings.
- Sub-module `mc_decode`: combinational; maps `op`/`funct` to a one-hot instruction class (rtype_add, rtype_sub, ori, lui, lw, sw, beq, j, jal, illegal).
- The FSM is one state register plus next-state logic and output logic.

## Test plan
- Reset for 2 cycles, then addu (op 0, funct 0x21) → state sequence 0,1,2,3,0.
  - `pcW`=1 only in the IF cycle.
  - `regW`=1 with `regDst`=1 only in the WB_R cycle.
- lw (0x23) then sw (0x2B):
  - lw: states 0,1,6,7,9 with `regW`/`wbSel`=1 in WB_LD.
  - sw: states 0,1,6,8 with `memW`=1 exactly once.
- beq with `zero`=1 → BR asserts `pcW`=1, `pcSrc`=1. Repeat with `zero`=0 → `pcW`=0 in BR; 3 cycles each.
- jal (0x03) → ID cycle has `pcW`=1, `pcSrc`=2, `regW`=1, `regDst`=2, `wbSel`=2; next state IF.
- op 0x3F, then R-type with funct 0x00 → `illegal`=1 for one cycle in ID, no write strobes, return to IF.
- Assert `Reset` while in MEM_WR → `memW`=0 that cycle; `state`=0 on the next edge.
